cache_axi_master: RTL and testbench

CACHE_AXI_MASTER -- requirements
Module: cache_axi_master

---
 rtl/cache_axi_master_pkg.sv | 40 ++++
 rtl/cache_axi_master.sv | 167 ++++++++++++++++
 tb/tb_cache_axi_master.sv | 276 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/cache_axi_master_pkg.sv
// Shared AXI definitions for the cache-side AXI4 master.
// Contents:
//   state_e      - FSM state encoding (also exported on the debug port)
//   axi_burst_e  - AxBURST encodings
//   axi_resp_e   - xRESP encodings
//   AXI_SIZE_4B  - AxSIZE for 32-bit beats
//   next_beat()  - beat counter step that wraps at the burst's last beat
package cache_axi_master_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RADDR = 3'd1,
    ST_RDATA = 3'd2,
    ST_WADDR = 3'd3,
    ST_WDATA = 3'd4,
    ST_WRESP = 3'd5,
    ST_DONE  = 3'd6
  } state_e;

  typedef enum logic [1:0] {
    BURST_FIXED = 2'b00,
    BURST_INCR  = 2'b01,
    BURST_WRAP  = 2'b10
  } axi_burst_e;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'b00,
    RESP_EXOKAY = 2'b01,
    RESP_SLVERR = 2'b10,
    RESP_DECERR = 2'b11
  } axi_resp_e;

  localparam logic [2:0] AXI_SIZE_4B = 3'd2;

  // Wrapping at the burst's own last beat keeps the counter inside 0..LEN.
  function automatic logic [3:0] next_beat(input logic [3:0] idx, input logic [3:0] last);
    return (idx == last) ? 4'd0 : idx + 4'd1;
  endfunction

endpackage

// File: rtl/cache_axi_master.sv
// Cache-side AXI4 master: issues one single-word or full-line read/write
// burst per accepted core request and reports completion.
// Ports:
//   ACLK, ARESETn          - clock, asynchronous active-low reset
//   core_req/write/line    - request strobe, direction, line-vs-word select
//   core_addr, core_wstrb  - byte address, single-word write strobe
//   core_wdata             - write data for the beat selected by beat_idx
//   beat_idx               - current beat number within the burst
//   rd_valid, rd_data      - read beat presentation to the core
//   core_busy/done/err     - in-flight flag, completion pulse, error status
//   AR*/R*/AW*/W*/B*       - AXI4 master channels
//   dbg_state              - current FSM state
// Handshakes: a beat transfers on a rising ACLK edge where VALID && READY.
// VALID is never withdrawn before its handshake, and address/control stay
// stable while VALID is high. READY is only raised in the state that
// expects that channel, so stray RVALID/BVALID are never consumed.
module cache_axi_master
  import cache_axi_master_pkg::*;
#(
  parameter logic [3:0] AXI_ID     = 4'd1,
  parameter int         LINE_WORDS = 4,
  parameter int         ADDR_W     = 32
) (
  input  logic              ACLK,
  input  logic              ARESETn,
  input  logic              core_req,
  input  logic              core_write,
  input  logic              core_line,
  input  logic [ADDR_W-1:0] core_addr,
  input  logic [3:0]        core_wstrb,
  input  logic [31:0]       core_wdata,
  output logic [3:0]        beat_idx,
  output logic              rd_valid,
  output logic [31:0]       rd_data,
  output logic              core_busy,
  output logic              core_done,
  output logic              core_err,
  output logic [3:0]        ARID,
  output logic [ADDR_W-1:0] ARADDR,
  output logic [3:0]        ARLEN,
  output logic [2:0]        ARSIZE,
  output logic [1:0]        ARBURST,
  output logic              ARVALID,
  input  logic              ARREADY,
  input  logic [31:0]       RDATA,
  input  logic [1:0]        RRESP,
  input  logic              RLAST,
  input  logic              RVALID,
  output logic              RREADY,
  output logic [3:0]        AWID,
  output logic [ADDR_W-1:0] AWADDR,
  output logic [3:0]        AWLEN,
  output logic [2:0]        AWSIZE,
  output logic [1:0]        AWBURST,
  output logic              AWVALID,
  input  logic              AWREADY,
  output logic [31:0]       WDATA,
  output logic [3:0]        WSTRB,
  output logic              WLAST,
  output logic              WVALID,
  input  logic              WREADY,
  input  logic [1:0]        BRESP,
  input  logic              BVALID,
  output logic              BREADY,
  output state_e            dbg_state
);

  localparam logic [ADDR_W-1:0] LINE_MASK = ADDR_W'(LINE_WORDS * 4 - 1);
  localparam logic [ADDR_W-1:0] WORD_MASK = ADDR_W'(3);
  localparam logic [3:0]        LINE_LEN  = 4'(LINE_WORDS - 1);

  state_e              state_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [3:0]          len_q;
  logic [3:0]          strb_q;
  logic [3:0]          idx_q;
  logic                err_q;

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      len_q   <= '0;
      strb_q  <= '0;
      idx_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (core_req) begin
            addr_q  <= core_line ? (core_addr & ~LINE_MASK) : (core_addr & ~WORD_MASK);
            len_q   <= core_line ? LINE_LEN : 4'd0;
            // Line writes always carry whole words.
            strb_q  <= core_line ? 4'hF : core_wstrb;
            idx_q   <= 4'd0;
            err_q   <= 1'b0;
            state_q <= core_write ? ST_WADDR : ST_RADDR;
          end
        end
        ST_RADDR: if (ARREADY) state_q <= ST_RDATA;
        ST_RDATA: begin
          if (RVALID) begin
            // Flag a burst whose RLAST position disagrees with the requested length.
            if ((RLAST != (idx_q == len_q)) || (RRESP != RESP_OKAY)) err_q <= 1'b1;
            idx_q <= next_beat(idx_q, len_q);
            if (RLAST) state_q <= ST_DONE;
          end
        end
        ST_WADDR: if (AWREADY) state_q <= ST_WDATA;
        ST_WDATA: begin
          if (WREADY) begin
            idx_q <= next_beat(idx_q, len_q);
            if (idx_q == len_q) state_q <= ST_WRESP;
          end
        end
        ST_WRESP: begin
          if (BVALID) begin
            if (BRESP != RESP_OKAY) err_q <= 1'b1;
            state_q <= ST_DONE;
          end
        end
        ST_DONE: state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  logic ar_act;
  logic aw_act;
  logic w_act;

  assign ar_act = (state_q == ST_RADDR);
  assign aw_act = (state_q == ST_WADDR);
  assign w_act  = (state_q == ST_WDATA);

  // Address channel fields are zeroed whenever the matching VALID is low.
  assign ARVALID = ar_act;
  assign ARID    = ar_act ? AXI_ID : 4'd0;
  assign ARADDR  = ar_act ? addr_q : '0;
  assign ARLEN   = ar_act ? len_q : 4'd0;
  assign ARSIZE  = ar_act ? AXI_SIZE_4B : 3'd0;
  assign ARBURST = ar_act ? BURST_INCR : BURST_FIXED;

  assign AWVALID = aw_act;
  assign AWID    = aw_act ? AXI_ID : 4'd0;
  assign AWADDR  = aw_act ? addr_q : '0;
  assign AWLEN   = aw_act ? len_q : 4'd0;
  assign AWSIZE  = aw_act ? AXI_SIZE_4B : 3'd0;
  assign AWBURST = aw_act ? BURST_INCR : BURST_FIXED;

  assign WVALID = w_act;
  assign WDATA  = w_act ? core_wdata : 32'd0;
  assign WSTRB  = w_act ? strb_q : 4'd0;
  assign WLAST  = w_act && (idx_q == len_q);

  assign RREADY = (state_q == ST_RDATA);
  assign BREADY = (state_q == ST_WRESP);

  assign rd_valid  = RVALID && RREADY;
  assign rd_data   = rd_valid ? RDATA : 32'd0;
  assign beat_idx  = idx_q;
  assign core_busy = (state_q != ST_IDLE);
  assign core_done = (state_q == ST_DONE);
  assign core_err  = core_done && err_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_cache_axi_master.sv
module tb_cache_axi_master;
  import cache_axi_master_pkg::*;

  localparam int LW = 4;

  // ---------------- clock / reset ----------------
  logic ACLK = 1'b0;
  logic ARESETn = 1'b0;
  always #5 ACLK = ~ACLK;

  logic        core_req = 0, core_write = 0, core_line = 0;
  logic [31:0] core_addr = 0;
  logic [3:0]  core_wstrb = 0;
  logic [31:0] core_wdata;
  logic [3:0]  beat_idx;
  logic        rd_valid, core_busy, core_done, core_err;
  logic [31:0] rd_data;
  logic [3:0]  ARID, ARLEN, AWID, AWLEN, WSTRB;
  logic [31:0] ARADDR, AWADDR, WDATA;
  logic [2:0]  ARSIZE, AWSIZE;
  logic [1:0]  ARBURST, AWBURST;
  logic        ARVALID, AWVALID, WVALID, WLAST, RREADY, BREADY;
  logic        ARREADY = 0, AWREADY = 0, WREADY = 0, RVALID = 0, RLAST = 0, BVALID = 0;
  logic [31:0] RDATA = 0;
  logic [1:0]  RRESP = 0, BRESP = 0;
  state_e      dbg_state;

  logic [31:0] wbuf [16];
  assign core_wdata = wbuf[beat_idx];

  cache_axi_master #(.AXI_ID(4'd1), .LINE_WORDS(LW), .ADDR_W(32)) dut (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .core_req(core_req), .core_write(core_write), .core_line(core_line),
    .core_addr(core_addr), .core_wstrb(core_wstrb), .core_wdata(core_wdata),
    .beat_idx(beat_idx), .rd_valid(rd_valid), .rd_data(rd_data),
    .core_busy(core_busy), .core_done(core_done), .core_err(core_err),
    .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE), .ARBURST(ARBURST),
    .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY),
    .AWID(AWID), .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE), .AWBURST(AWBURST),
    .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
    .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
    .dbg_state(dbg_state)
  );

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q [$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic any_out();
    return |{ARVALID, ARID, ARADDR, ARLEN, ARSIZE, ARBURST,
             AWVALID, AWID, AWADDR, AWLEN, AWSIZE, AWBURST,
             WVALID, WDATA, WSTRB, WLAST, RREADY, BREADY,
             beat_idx, rd_valid, rd_data, core_busy, core_done, core_err};
  endfunction

  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  // ---------------- vectors and reference model ----------------
  typedef struct {
    bit          write;
    bit          line;
    logic [31:0] addr;
    logic [3:0]  wstrb;
    int          ax_delay;
    int          err_beat;   // read beat carrying SLVERR, -1 none
    int          rlast_at;   // early RLAST beat, -1 = natural end
    logic [1:0]  bresp;
    bit          poke;       // keep core_req asserted while busy
    int          rst_beat;   // assert reset on this read beat, -1 none
    bit          alt_wready; // WREADY 1,0,1,0 and data 0..N-1
    logic [31:0] exp_addr;
    logic [3:0]  exp_len;
    bit          exp_err;
  } vec_t;

  function automatic vec_t mk(input bit w, input bit l, input logic [31:0] a, input logic [3:0] s,
                              input int dly, input int eb, input int rl, input logic [1:0] br,
                              input bit pk, input int rb, input bit alt,
                              input logic [31:0] ea, input logic [3:0] el, input bit ee);
    vec_t v;
    v.write = w; v.line = l; v.addr = a; v.wstrb = s; v.ax_delay = dly;
    v.err_beat = eb; v.rlast_at = rl; v.bresp = br; v.poke = pk; v.rst_beat = rb;
    v.alt_wready = alt; v.exp_addr = ea; v.exp_len = el; v.exp_err = ee;
    return v;
  endfunction

  // Expected results from the protocol rules: align down to the transfer span,
  // length from the line size, error from any bad response or misplaced RLAST.
  function automatic vec_t model(input vec_t v);
    int unsigned span;
    int nb;
    span = v.line ? LW * 4 : 4;
    v.exp_addr = v.addr - (v.addr % span);
    v.exp_len = v.line ? 4'(LW - 1) : 4'd0;
    if (v.write) v.exp_err = (v.bresp != 2'b00);
    else begin
      nb = (v.rlast_at >= 0) ? v.rlast_at + 1 : int'(v.exp_len) + 1;
      v.exp_err = (v.err_beat >= 0 && v.err_beat < nb) || (nb != int'(v.exp_len) + 1);
    end
    return v;
  endfunction

  // ---------------- driver: core request + AXI slave ----------------
  task automatic run_txn(input vec_t v);
    int k;
    int budget;
    int nbeats;
    logic [3:0] exp_strb;
    exp_strb = v.line ? 4'hF : v.wstrb;
    for (int i = 0; i < 16; i++) wbuf[i] = v.alt_wready ? 32'(i) : $urandom;
    exp_q.delete();

    core_req = 1; core_write = v.write; core_line = v.line;
    core_addr = v.addr; core_wstrb = v.wstrb;
    tick();
    if (v.poke) begin
      core_addr = ~v.addr; core_write = ~v.write; core_line = ~v.line; core_wstrb = ~v.wstrb;
    end else core_req = 0;

    // Address phase: first iteration is the cycle right after the request.
    for (int d = 0; d <= v.ax_delay; d++) begin
      if (v.write) AWREADY = (d == v.ax_delay); else ARREADY = (d == v.ax_delay);
      settle();
      if (v.write) begin
        chk("awvalid", AWVALID, 1); chk("awaddr", AWADDR, v.exp_addr); chk("awlen", AWLEN, v.exp_len);
        chk("awsize", AWSIZE, 2); chk("awburst", AWBURST, 1); chk("awid", AWID, 1);
      end else begin
        chk("arvalid", ARVALID, 1); chk("araddr", ARADDR, v.exp_addr); chk("arlen", ARLEN, v.exp_len);
        chk("arsize", ARSIZE, 2); chk("arburst", ARBURST, 1); chk("arid", ARID, 1);
      end
      tick();
    end
    ARREADY = 0; AWREADY = 0;

    if (!v.write) begin
      nbeats = (v.rlast_at >= 0) ? v.rlast_at + 1 : int'(v.exp_len) + 1;
      for (int kk = 0; kk < nbeats; kk++) begin
        repeat ($urandom_range(0, 2)) begin
          RVALID = 0; settle();
          chk("rready", RREADY, 1); chk("rd_valid_gap", rd_valid, 0);
          tick();
        end
        RVALID = 1; RDATA = $urandom; RRESP = (kk == v.err_beat) ? 2'b10 : 2'b00;
        RLAST = (kk == nbeats - 1);
        if (kk == v.rst_beat) begin
          ARESETn = 0; settle();
          chk("rst_outputs_low", any_out(), 0);
          RVALID = 0; RLAST = 0; RRESP = 0;
          repeat (3) begin
            tick(); settle();
            chk("rst_no_done", core_done, 0); chk("rst_not_busy", core_busy, 0);
          end
          ARESETn = 1; core_req = 0;
          tick();
          return;
        end
        settle();
        chk("rd_valid", rd_valid, 1); chk("rd_data", rd_data, RDATA); chk("rd_idx", beat_idx, kk);
        tick();
      end
      RVALID = 0; RLAST = 0; RRESP = 0;
    end else begin
      for (int i = 0; i <= int'(v.exp_len); i++) exp_q.push_back(wbuf[i]);
      k = 0; budget = 0;
      while (k <= int'(v.exp_len) && budget < 64) begin
        WREADY = v.alt_wready ? (budget % 2 == 0) : 1'($urandom_range(0, 1));
        settle();
        chk("wvalid", WVALID, 1); chk("w_idx", beat_idx, k); chk("wlast", WLAST, k == int'(v.exp_len));
        if (WREADY) begin
          chk("wdata", WDATA, exp_q.pop_front()); chk("wstrb", WSTRB, exp_strb);
          k++;
        end
        tick(); budget++;
      end
      WREADY = 0;
      chk("w_beats_sent", k, int'(v.exp_len) + 1);
      repeat ($urandom_range(0, 2)) begin
        settle(); chk("bready_wait", BREADY, 1); tick();
      end
      BVALID = 1; BRESP = v.bresp; settle();
      chk("bready", BREADY, 1);
      tick();
      BVALID = 0; BRESP = 0;
    end

    settle();
    for (int i = 0; i < 4 && !core_done; i++) begin tick(); settle(); end
    chk("core_done", core_done, 1);
    chk("core_err", core_err, v.exp_err);
    core_req = 0;
    tick(); settle();
    chk("done_one_cycle", core_done, 0);
    chk("back_to_idle", core_busy, 0);
  endtask

  // ---------------- main ----------------
  vec_t tbl [11];
  vec_t rv;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0]  = mk(0, 1, 32'h0000_1234, 4'h0,   0, -1, -1, 2'b00, 0, -1, 0, 32'h0000_1230, 4'd3, 0);
    tbl[1]  = mk(1, 0, 32'h0000_2006, 4'hC,   3, -1, -1, 2'b00, 0, -1, 0, 32'h0000_2004, 4'd0, 0);
    tbl[2]  = mk(1, 1, 32'h0000_3010, 4'h0,   1, -1, -1, 2'b00, 0, -1, 1, 32'h0000_3010, 4'd3, 0);
    tbl[3]  = mk(0, 1, 32'h0000_4008, 4'h0,   0,  1, -1, 2'b00, 0, -1, 0, 32'h0000_4000, 4'd3, 1);
    tbl[4]  = mk(0, 1, 32'h0000_400C, 4'h0,   2, -1,  2, 2'b00, 0, -1, 0, 32'h0000_4000, 4'd3, 1);
    tbl[5]  = mk(1, 0, 32'h0000_5003, 4'h3,   0, -1, -1, 2'b10, 0, -1, 0, 32'h0000_5000, 4'd0, 1);
    tbl[6]  = mk(0, 0, 32'h0000_60FF, 4'h0,   1, -1, -1, 2'b00, 0, -1, 0, 32'h0000_60FC, 4'd0, 0);
    tbl[7]  = mk(0, 1, 32'h0000_703C, 4'h0,   2, -1, -1, 2'b00, 1, -1, 0, 32'h0000_7030, 4'd3, 0);
    tbl[8]  = mk(0, 1, 32'h0000_8000, 4'h0,   0, -1, -1, 2'b00, 0,  2, 0, 32'h0000_8000, 4'd3, 0);
    tbl[9]  = mk(0, 1, 32'h0000_9008, 4'h0,   0, -1, -1, 2'b00, 0, -1, 0, 32'h0000_9000, 4'd3, 0);
    tbl[10] = mk(1, 1, 32'h0000_A01C, 4'h0,   0, -1, -1, 2'b11, 1, -1, 0, 32'h0000_A010, 4'd3, 1);

    // Reset state.
    #2;
    chk("reset_outputs_low", any_out(), 0);
    chk("reset_state", dbg_state, ST_IDLE);
    #10 ARESETn = 1;
    tick();

    // Stray responses while idle must not be accepted.
    RVALID = 1; BVALID = 1; RDATA = 32'hDEAD_BEEF; settle();
    chk("idle_rready", RREADY, 0); chk("idle_bready", BREADY, 0);
    chk("idle_rd_valid", rd_valid, 0); chk("idle_rd_data", rd_data, 0);
    tick();
    chk("idle_stays", core_busy, 0);
    RVALID = 0; BVALID = 0; RDATA = 0;

    // Directed table.
    for (int i = 0; i < 11; i++) run_txn(tbl[i]);

    // Randomized transactions against the reference model.
    for (int n = 0; n < 40; n++) begin
      rv.write = 1'($urandom_range(0, 1));
      rv.line = 1'($urandom_range(0, 1));
      rv.addr = $urandom;
      rv.wstrb = 4'($urandom_range(1, 15));
      rv.ax_delay = $urandom_range(0, 3);
      rv.err_beat = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, rv.line ? LW - 1 : 0)) : -1;
      rv.rlast_at = (!rv.write && rv.line && $urandom_range(0, 4) == 0) ? int'($urandom_range(0, LW - 2)) : -1;
      rv.bresp = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      rv.poke = ($urandom_range(0, 3) == 0);
      rv.rst_beat = -1;
      rv.alt_wready = 0;
      rv = model(rv);
      run_txn(rv);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
